// File: rtl/scene_anim_sequencer.sv
// -----------------------------------------------------------------------------
// scene_anim_sequencer
//
// Frame-synchronous animation controller for the VGA Christmas scene.
// Counts frames from the timing generator and, on each animation step, walks a
// small FSM that updates every moving object (4 snowflakes, 2 oscillating
// stars, star colour, ornament blink) one object per cycle through a single
// shared 11-bit add/subtract unit. Results live in working registers and are
// copied to the outputs on one edge (COMMIT), so the pixel painter never sees
// a half-updated scene.
//
// Ports:
//   CLK         system clock
//   rst         asynchronous, active-high reset
//   frame_tick  1-cycle pulse at start of vertical blanking
//   run         1 = automatic stepping every FRAMES_PER_STEP frames, 0 = paused
//   step_req    1-cycle manual step request (honoured only while paused & idle)
//   busy        high while the update FSM is not IDLE
//   step_done   1-cycle pulse in the first cycle the new values are visible
//   snow_a..d   flake centre rows
//   star0_row   vertically oscillating star centre row
//   star1_col   horizontally oscillating star centre column
//   star_r/g/b  oscillating-star colour
//   blink       ornament blink phase
// -----------------------------------------------------------------------------
module scene_anim_sequencer #(
  parameter int FRAMES_PER_STEP = 36,
  parameter int STEP            = 5,
  parameter int SNOW_LIMIT      = 630
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        step_req,
  output logic        busy,
  output logic        step_done,
  output logic [10:0] snow_a,
  output logic [10:0] snow_b,
  output logic [10:0] snow_c,
  output logic [10:0] snow_d,
  output logic [10:0] star0_row,
  output logic [10:0] star1_col,
  output logic        star_r,
  output logic        star_g,
  output logic        star_b,
  output logic        blink
);

  localparam logic [10:0] SNOW_A_START = 11'd300;
  localparam logic [10:0] SNOW_B_START = 11'd100;
  localparam logic [10:0] SNOW_C_START = 11'd400;
  localparam logic [10:0] SNOW_D_START = 11'd200;
  localparam logic [10:0] STAR0_START  = 11'd150;
  localparam logic [10:0] STAR1_START  = 11'd740;
  localparam logic [10:0] STEP_W       = 11'(STEP);
  localparam logic [10:0] LIMIT_W      = 11'(SNOW_LIMIT);
  localparam logic [7:0]  FRAME_LAST   = 8'(FRAMES_PER_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNOW0, S_SNOW1, S_SNOW2, S_SNOW3, S_STAR, S_COLOR, S_COMMIT
  } state_t;

  state_t      state;
  logic [7:0]  frame_cnt;
  logic        trig;
  logic [2:0]  move_phase;
  logic [1:0]  color_phase;

  // Working copy of the scene, updated one object per cycle.
  logic [10:0] snow_w [4];
  logic [10:0] star0_w;
  logic [10:0] star1_w;
  logic [2:0]  rgb_w;
  logic        blink_w;

  // Star direction chosen in STAR, reused for the column in COLOR so both
  // stars move in lockstep while still sharing one adder.
  logic        dir_sub;
  logic        dir_hold;

  function automatic logic [10:0] snow_start(input logic [1:0] idx);
    case (idx)
      2'd0:    return SNOW_A_START;
      2'd1:    return SNOW_B_START;
      2'd2:    return SNOW_C_START;
      default: return SNOW_D_START;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Shared add/subtract unit
  // ---------------------------------------------------------------------------
  logic [10:0] add_a;
  logic        add_sub;
  logic        add_hold;
  logic [10:0] add_b;
  logic [10:0] add_y;
  logic [1:0]  snow_idx;
  logic        is_snow;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    add_a    = '0;
    add_sub  = 1'b0;
    add_hold = 1'b1;
    snow_idx = 2'd0;
    is_snow  = 1'b0;
    case (state)
      S_SNOW0: begin snow_idx = 2'd0; is_snow = 1'b1; end
      S_SNOW1: begin snow_idx = 2'd1; is_snow = 1'b1; end
      S_SNOW2: begin snow_idx = 2'd2; is_snow = 1'b1; end
      S_SNOW3: begin snow_idx = 2'd3; is_snow = 1'b1; end
      default: ;
    endcase
    if (is_snow) begin
      add_a    = snow_w[snow_idx];
      add_hold = 1'b0;
    end else if (state == S_STAR) begin
      add_a    = star0_w;
      add_sub  = (move_phase == 3'd2) || (move_phase == 3'd3);
      add_hold = (move_phase == 3'd4);
    end else if (state == S_COLOR) begin
      add_a    = star1_w;
      add_sub  = dir_sub;
      add_hold = dir_hold;
    end
  end

  assign add_b = add_hold ? 11'd0 : STEP_W;
  assign add_y = add_sub ? (add_a - add_b) : (add_a + add_b);

  // ---------------------------------------------------------------------------
  // Frame counter and trigger
  // ---------------------------------------------------------------------------
  logic auto_fire;
  assign auto_fire = frame_tick && run && (frame_cnt == FRAME_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      trig      <= 1'b0;
    end else begin
      if (frame_tick && run)
        frame_cnt <= auto_fire ? 8'd0 : frame_cnt + 8'd1;
      // Requests arriving while the FSM is busy are dropped, not queued.
      trig <= auto_fire || (step_req && !run && (state == S_IDLE));
    end
  end

  // ---------------------------------------------------------------------------
  // Update FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: the four working snow rows are a small register array, not RAM, so
  // they are reset alongside everything else.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      move_phase  <= '0;
      color_phase <= '0;
      snow_w[0]   <= SNOW_A_START;
      snow_w[1]   <= SNOW_B_START;
      snow_w[2]   <= SNOW_C_START;
      snow_w[3]   <= SNOW_D_START;
      star0_w     <= STAR0_START;
      star1_w     <= STAR1_START;
      rgb_w       <= '0;
      blink_w     <= 1'b0;
      dir_sub     <= 1'b0;
      dir_hold    <= 1'b0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      snow_a      <= SNOW_A_START;
      snow_b      <= SNOW_B_START;
      snow_c      <= SNOW_C_START;
      snow_d      <= SNOW_D_START;
      star0_row   <= STAR0_START;
      star1_col   <= STAR1_START;
      star_r      <= 1'b0;
      star_g      <= 1'b0;
      star_b      <= 1'b0;
      blink       <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig) begin
            state <= S_SNOW0;
            busy  <= 1'b1;
          end
        end
        S_SNOW0, S_SNOW1, S_SNOW2, S_SNOW3: begin
          snow_w[snow_idx] <= (snow_w[snow_idx] < LIMIT_W) ? add_y
                                                           : snow_start(snow_idx);
          case (state)
            S_SNOW0: state <= S_SNOW1;
            S_SNOW1: state <= S_SNOW2;
            S_SNOW2: state <= S_SNOW3;
            default: state <= S_STAR;
          endcase
        end
        S_STAR: begin
          star0_w    <= add_y;
          dir_sub    <= add_sub;
          dir_hold   <= add_hold;
          move_phase <= (move_phase == 3'd4) ? 3'd0 : move_phase + 3'd1;
          state      <= S_COLOR;
        end
        S_COLOR: begin
          star1_w <= add_y;
          case (color_phase)
            2'd0:    rgb_w <= 3'b000;
            2'd1:    rgb_w <= 3'b100;
            default: rgb_w <= 3'b111;
          endcase
          color_phase <= (color_phase == 2'd2) ? 2'd0 : color_phase + 2'd1;
          blink_w     <= ~blink_w;
          state       <= S_COMMIT;
        end
        S_COMMIT: begin
          snow_a    <= snow_w[0];
          snow_b    <= snow_w[1];
          snow_c    <= snow_w[2];
          snow_d    <= snow_w[3];
          star0_row <= star0_w;
          star1_col <= star1_w;
          star_r    <= rgb_w[2];
          star_g    <= rgb_w[1];
          star_b    <= rgb_w[0];
          blink     <= blink_w;
          busy      <= 1'b0;
          step_done <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scene_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scene_anim_sequencer
//
// Self-checking bench for scene_anim_sequencer (FRAMES_PER_STEP = 2). A
// behavioural model of the scene (integer positions, phase counters) predicts
// each step; directed scenarios cover reset, auto stepping, snow wrap, star
// oscillation, request filtering and reset mid-sequence, followed by
// randomized tick/request traffic.
// -----------------------------------------------------------------------------
module tb_scene_anim_sequencer;

  localparam int FPS = 2;

  logic        CLK;
  logic        rst;
  logic        frame_tick;
  logic        run;
  logic        step_req;
  logic        busy;
  logic        step_done;
  logic [10:0] snow_a, snow_b, snow_c, snow_d;
  logic [10:0] star0_row, star1_col;
  logic        star_r, star_g, star_b, blink;

  scene_anim_sequencer #(
    .FRAMES_PER_STEP(FPS),
    .STEP(5),
    .SNOW_LIMIT(630)
  ) dut (
    .CLK(CLK), .rst(rst), .frame_tick(frame_tick), .run(run),
    .step_req(step_req), .busy(busy), .step_done(step_done),
    .snow_a(snow_a), .snow_b(snow_b), .snow_c(snow_c), .snow_d(snow_d),
    .star0_row(star0_row), .star1_col(star1_col),
    .star_r(star_r), .star_g(star_g), .star_b(star_b), .blink(blink)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_snow [4];
  int m_start [4] = '{300, 100, 400, 200};
  int m_star0, m_star1, m_mphase, m_cphase, m_rgb, m_blink, m_fcnt;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_snow[i] = m_start[i];
    m_star0 = 150; m_star1 = 740;
    m_mphase = 0; m_cphase = 0; m_rgb = 0; m_blink = 0; m_fcnt = 0;
  endfunction

  function automatic void m_step();
    int d;
    for (int i = 0; i < 4; i++)
      m_snow[i] = (m_snow[i] < 630) ? m_snow[i] + 5 : m_start[i];
    d = (m_mphase < 2) ? 5 : (m_mphase < 4) ? -5 : 0;
    m_star0 += d;
    m_star1 += d;
    m_mphase = (m_mphase + 1) % 5;
    m_rgb = (m_cphase == 0) ? 0 : (m_cphase == 1) ? 4 : 7;
    m_cphase = (m_cphase + 1) % 3;
    m_blink = 1 - m_blink;
  endfunction

  function automatic logic [69:0] m_vec();
    return {11'(m_snow[0]), 11'(m_snow[1]), 11'(m_snow[2]), 11'(m_snow[3]),
            11'(m_star0), 11'(m_star1), 3'(m_rgb), 1'(m_blink)};
  endfunction

  function automatic logic [69:0] dut_vec();
    return {snow_a, snow_b, snow_c, snow_d, star0_row, star1_col,
            star_r, star_g, star_b, blink};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    m_reset();
  endtask

  // One tick or step_req pulse, then a cycle-by-cycle check of the response:
  // outputs hold for 7 cycles, new values and step_done appear 8 edges after
  // the sampling edge, busy covers the 7 cycles before that.
  task automatic do_event(input bit is_tick, input bit run_v, input string tag);
    bit trig;
    logic [69:0] old_v, new_v;
    @(negedge CLK);
    run = run_v;
    if (is_tick) frame_tick = 1'b1; else step_req = 1'b1;
    trig = 1'b0;
    if (is_tick) begin
      if (run_v) begin
        m_fcnt++;
        if (m_fcnt == FPS) begin m_fcnt = 0; trig = 1'b1; end
      end
    end else begin
      trig = !run_v;
    end
    old_v = m_vec();
    if (trig) m_step();
    new_v = m_vec();
    @(negedge CLK);
    frame_tick = 1'b0;
    step_req   = 1'b0;
    check({tag, "_busy0"}, 70'(busy), 70'(0));
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      if (k == 3) run = 1'($urandom_range(0, 1));
      if (k <= 7) begin
        check({tag, "_hold"}, dut_vec(), old_v);
        check({tag, "_busy"}, 70'(busy), 70'(trig));
        check({tag, "_sd_lo"}, 70'(step_done), 70'(0));
      end else if (k == 8) begin
        check({tag, "_new"}, dut_vec(), new_v);
        check({tag, "_busy_fall"}, 70'(busy), 70'(0));
        check({tag, "_sd"}, 70'(step_done), 70'(trig));
      end else begin
        check({tag, "_sd_end"}, 70'(step_done), 70'(0));
      end
    end
  endtask

  int exp_star0 [5] = '{155, 160, 155, 150, 150};
  int exp_star1 [5] = '{745, 750, 745, 740, 740};
  int exp_rgb   [5] = '{0, 4, 7, 0, 4};

  initial begin
    int sd_count;
    rst = 1'b1; frame_tick = 1'b0; run = 1'b0; step_req = 1'b0;
    m_reset();
    repeat (3) @(negedge CLK);
    rst = 1'b0;

    // 1. reset state
    repeat (100) @(negedge CLK);
    check("reset_vec", dut_vec(), {11'd300, 11'd100, 11'd400, 11'd200, 11'd150, 11'd740, 4'b0});
    check("reset_busy", 70'(busy), 70'(0));
    check("reset_sd", 70'(step_done), 70'(0));

    // 2. automatic step after two ticks
    do_event(1'b1, 1'b1, "auto_t1");
    do_event(1'b1, 1'b1, "auto_t2");
    check("auto_vec", dut_vec(), {11'd305, 11'd105, 11'd405, 11'd205, 11'd155, 11'd745, 4'b0001});

    // 3. snow wrap
    do_reset();
    for (int i = 1; i <= 67; i++) begin
      do_event(1'b0, 1'b0, "wrap");
      if (i == 66) begin
        check("snow_a_66", 70'(snow_a), 70'(630));
        check("snow_b_66", 70'(snow_b), 70'(430));
      end
      if (i == 67) check("snow_a_67", 70'(snow_a), 70'(300));
    end

    // 4. star oscillation and colour
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_event(1'b0, 1'b0, "star");
      check("star0_tbl", 70'(star0_row), 70'(exp_star0[i]));
      check("star1_tbl", 70'(star1_col), 70'(exp_star1[i]));
      check("rgb_tbl", 70'({star_r, star_g, star_b}), 70'(exp_rgb[i]));
    end

    // 5. request filtering
    do_reset();
    do_event(1'b0, 1'b1, "req_run");
    do_event(1'b1, 1'b1, "frz_t1");
    do_event(1'b1, 1'b0, "frz_off1");
    do_event(1'b1, 1'b0, "frz_off2");
    do_event(1'b1, 1'b0, "frz_off3");
    do_event(1'b1, 1'b1, "frz_t2");
    // step_req while busy: only one step results
    @(negedge CLK);
    run = 1'b0; step_req = 1'b1;
    @(negedge CLK);
    step_req = 1'b0;
    m_step();
    sd_count = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) step_req = 1'b1;
      if (k == 3) step_req = 1'b0;
      @(negedge CLK);
      if (step_done) sd_count++;
    end
    check("busy_req_sd_count", 70'(sd_count), 70'(1));
    check("busy_req_vec", dut_vec(), m_vec());

    // 6. reset during the STAR cycle
    @(negedge CLK);
    run = 1'b0; step_req = 1'b1;
    @(posedge CLK);
    #1 step_req = 1'b0;
    repeat (5) @(posedge CLK);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("midrst_vec", dut_vec(), m_vec());
    check("midrst_busy", 70'(busy), 70'(0));
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    sd_count = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (step_done) sd_count++;
    end
    check("midrst_no_sd", 70'(sd_count), 70'(0));
    check("midrst_vec_after", dut_vec(), m_vec());

    // 7. randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      do_event(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    check("rand_final", dut_vec(), m_vec());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scene_anim_sequencer.md
Name: scene_anim_sequencer

Overview:
- Frame-synchronous animation controller for the VGA Christmas scene renderer.
- Counts frames from the timing generator and decides when an animation step occurs.
- Updates all moving-object state (4 snowflakes, 2 oscillating stars, star colour, blink) through one shared ±5 adder, one object per cycle.
- Commits the results atomically during vertical blanking, so the pixel painter never sees a half-updated scene.

Parameters:
- FRAMES_PER_STEP, 36, frame_ticks per automatic step; about 0.5 s at 72 Hz (1040x666 frame). Legal range 1..255.
- STEP, 5, pixel increment applied to every moving coordinate.
- SNOW_LIMIT, 630, a flake row at or above this value reloads its start row.

Ports:
- CLK  in  1  system clock
- rst  in  1  reset: asynchronous, active-high; clock CLK
- frame_tick  in  1  single-cycle pulse at start of vertical blanking (row 659, col 0)
- run  in  1  1 = automatic stepping; 0 = paused
- step_req  in  1  single-cycle manual step request, honoured only when run=0
- busy  out  1  high while the update FSM is not IDLE
- step_done  out  1  single-cycle pulse in the first cycle the new values are visible
- snow_a, snow_b, snow_c, snow_d  out  11 each  flake centre rows
- star0_row  out  11  vertically oscillating star centre row
- star1_col  out  11  horizontally oscillating star centre column
- star_r, star_g, star_b  out  1 each  oscillating-star colour
- blink  out  1  ornament blink phase; drives the ornament blue channel

Behaviour:
- Reset values:
  - Outputs: snow_a/b/c/d = 300/100/400/200; star0_row = 150; star1_col = 740; star rgb = 000; blink = 0; busy = 0; step_done = 0.
  - Internals: frame counter = 0, move phase = 0, colour phase = 0, FSM = IDLE, working registers equal to the output values.
- Frame counter:
  - Advances on frame_tick only while run=1. Holds its value while run=0.
  - On a frame_tick with count == FRAMES_PER_STEP-1, it clears to 0 and raises the trigger.
- Manual trigger: step_req with run=0 and FSM IDLE.
- Ignored requests: step_req while run=1, and any trigger or step_req while busy. Neither is queued.
- FSM sequence: IDLE -> SNOW0 -> SNOW1 -> SNOW2 -> SNOW3 -> STAR -> COLOR -> COMMIT -> IDLE, one cycle per state.
  - IDLE is left on the edge that samples the trigger.
- SNOWn: working_n <= (working_n < SNOW_LIMIT) ? working_n + STEP : start_n. Start rows are 300/100/400/200.
- STAR: the move phase selects the update for both star0 row and star1 col:
  - Phase 0 or 1: + STEP.
  - Phase 2 or 3: - STEP.
  - Phase 4: hold.
  - The phase then advances 0..4 and wraps to 0.
- COLOR:
  - rgb is set from the colour phase before it advances: phase 0 -> 000, 1 -> 100, 2 -> 111. The phase then advances 0..2 and wraps.
  - blink toggles.
- Adder: exactly one shared 11-bit adder/subtractor serves all coordinate updates. Arithmetic is modulo 2048; in-range use never wraps.
- COMMIT: all output registers load from the working registers on the same edge.
  - step_done is high, and busy falls, in the following cycle.
- Latency: new outputs appear 8 clock edges after the edge that sampled the trigger, which is inside blanking (6 lines).
- Outputs are stable at all times except at the commit edge.
- Reset mid-sequence: every register returns immediately to its reset value and no partial commit occurs.
- run toggling mid-sequence does not abort the sequence.

Test Plan:
1. Reset: assert rst, release, idle for 100 cycles -> snow 300/100/400/200, star0_row 150, star1_col 740, rgb 000, blink 0, busy 0.
2. Auto step with FRAMES_PER_STEP=2, run=1, two frame_ticks:
   - Outputs unchanged until 8 edges after the 2nd tick.
   - Then snow 305/105/405/205, star0_row 155, star1_col 745, rgb 000, blink 1.
   - step_done high for exactly 1 cycle; busy high for the 7 cycles before it.
3. Snow wrap: paused, issue 67 step_reqs spaced at least 10 cycles apart -> snow_a reads 630 after step 66 and 300 after step 67; snow_b reads 430 after step 66.
4. Star oscillation and colour over 5 manual steps:
   - star0_row 155, 160, 155, 150, 150.
   - star1_col 745, 750, 745, 740, 740.
   - rgb 000, 100, 111, 000, 100.
5. Request filtering: step_req while run=1 -> no change. step_req during busy -> ignored, only one step_done. frame_ticks with run=0 -> counter frozen.
6. Reset mid-sequence: assert rst in the STAR cycle of a step -> all outputs at reset values, busy 0, no step_done pulse.
